// File: rtl/sa_xaddr_arbiter_pkg.sv
// sa_xaddr_arbiter_pkg: shared interconnect widths and the order-FIFO entry layout
package sa_xaddr_arbiter_pkg;
   localparam int ADDR_WIDTH        = 32;
   localparam int TRANS_MST_ID_W    = 5;
   localparam int TRANS_BURST_W     = 2;
   localparam int TRANS_DATA_LEN_W  = 3;
   localparam int TRANS_DATA_SIZE_W = 3;
   localparam int DFLT_MST_AMT      = 2;
   localparam int DFLT_MST_ID_W     = $clog2(DFLT_MST_AMT);

   typedef struct packed {
      logic [DFLT_MST_ID_W-1:0]    mstIdx;
      logic [TRANS_DATA_LEN_W-1:0] len;
   } ordEntry_t;
endpackage

// File: rtl/fifo.sv
// fifo: synchronous FIFO with occupancy counter and asynchronous active-high reset
module fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         dataIn,
   input  logic                          push,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         dataOut,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CTN_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr, rdPtr;
   logic                  doPush, doPop;

   assign full    = count == CTN_W'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign doPush  = push & ~full;
   assign doPop   = pop & ~empty;
   assign dataOut = mem[rdPtr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= (wrPtr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wrPtr + 1'b1;
         if (doPop) rdPtr <= (rdPtr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rdPtr + 1'b1;
         count <= count + CTN_W'(doPush) - CTN_W'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= dataIn;
   end
endmodule

// File: rtl/sa_xaddr_arbiter.sv
// sa_xaddr_arbiter: round-robin slave-side AW/AR arbiter with registered output and xDATA order FIFO
module sa_xaddr_arbiter
   import sa_xaddr_arbiter_pkg::*;
#(
   parameter int MST_AMT         = DFLT_MST_AMT,
   parameter int OUTSTANDING_AMT = 8,
   parameter int OUTST_CTN_W     = $clog2(OUTSTANDING_AMT) + 1,
   parameter int MST_ID_W        = $clog2(MST_AMT),
   parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W
) (
   input  logic                                  ACLK_i,
   input  logic                                  ARESET_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AxID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AxADDR_i,
   input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AxBURST_i,
   input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AxLEN_i,
   input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AxSIZE_i,
   input  logic [MST_AMT-1:0]                    dsp_AxVALID_i,
   output logic [MST_AMT-1:0]                    dsp_AxREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]             s_AxID_o,
   output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
   output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
   output logic                                  s_AxVALID_o,
   input  logic                                  s_AxREADY_i,
   input  logic                                  s_xVALID_i,
   input  logic                                  s_xREADY_i,
   output logic [MST_ID_W-1:0]                   xDATA_mst_id_o,
   output logic                                  xDATA_disable_o,
   output logic [OUTST_CTN_W-1:0]                outst_ctn_o
);
   logic                        take, grantEn, fifoFull, fifoEmpty, dataHs, lastBeat;
   logic [MST_ID_W-1:0]         rrPtr, winner;
   logic [TRANS_DATA_LEN_W-1:0] beatCtn;
   ordEntry_t                   pushEntry, headEntry;

   // Scan from the farthest offset down so the nearest requester above rrPtr wins
   always_comb begin
      winner = '0;
      for (int i = MST_AMT - 1; i >= 0; i--) begin
         if (dsp_AxVALID_i[(int'(rrPtr) + i) % MST_AMT]) winner = MST_ID_W'((int'(rrPtr) + i) % MST_AMT);
      end
   end

   assign take          = ~s_AxVALID_o | s_AxREADY_i;
   assign grantEn       = take & ~fifoFull & (|dsp_AxVALID_i) & ~ARESET_i;
   assign dsp_AxREADY_o = grantEn ? MST_AMT'(1) << winner : '0;
   assign pushEntry     = '{mstIdx: winner, len: dsp_AxLEN_i[winner*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W]};

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         s_AxVALID_o <= 1'b0;
         s_AxID_o    <= '0;
         s_AxADDR_o  <= '0;
         s_AxBURST_o <= '0;
         s_AxLEN_o   <= '0;
         s_AxSIZE_o  <= '0;
         rrPtr       <= '0;
      end else if (grantEn) begin
         s_AxVALID_o <= 1'b1;
         s_AxID_o    <= {winner, dsp_AxID_i[winner*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
         s_AxADDR_o  <= dsp_AxADDR_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
         s_AxBURST_o <= dsp_AxBURST_i[winner*TRANS_BURST_W +: TRANS_BURST_W];
         s_AxLEN_o   <= dsp_AxLEN_i[winner*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
         s_AxSIZE_o  <= dsp_AxSIZE_i[winner*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
         rrPtr       <= (winner == MST_ID_W'(MST_AMT - 1)) ? '0 : winner + 1'b1;
      end else if (s_AxREADY_i) begin
         s_AxVALID_o <= 1'b0;
      end
   end

   assign dataHs   = s_xVALID_i & s_xREADY_i & ~fifoEmpty;
   assign lastBeat = dataHs & (beatCtn == headEntry.len);

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) beatCtn <= '0;
      else if (lastBeat) beatCtn <= '0;
      else if (dataHs) beatCtn <= beatCtn + 1'b1;
   end

   fifo #(
      .DATA_WIDTH(MST_ID_W + TRANS_DATA_LEN_W),
      .FIFO_DEPTH(OUTSTANDING_AMT)
   ) orderFifo (
      .clk    (ACLK_i),
      .rst    (ARESET_i),
      .dataIn (pushEntry),
      .push   (grantEn),
      .pop    (lastBeat),
      .dataOut(headEntry),
      .empty  (fifoEmpty),
      .full   (fifoFull),
      .count  (outst_ctn_o)
   );

   assign xDATA_disable_o = fifoEmpty;
   assign xDATA_mst_id_o  = fifoEmpty ? '0 : headEntry.mstIdx;
endmodule

// File: tb/tb_sa_xaddr_arbiter.sv
// tb_sa_xaddr_arbiter: directed and random stimulus checked every cycle against a queue-based model
module tb_sa_xaddr_arbiter;
   import sa_xaddr_arbiter_pkg::*;

   logic ACLK_i = 1'b0;
   logic ARESET_i = 1'b1;
   always #5 ACLK_i = ~ACLK_i;

   logic [4:0]  rqId    [2];
   logic [31:0] rqAddr  [2];
   logic [1:0]  rqBurst [2];
   logic [2:0]  rqLen   [2];
   logic [2:0]  rqSize  [2];
   logic [1:0]  have;
   logic        sReady, xValid, xReady;

   logic [9:0]  dsp_AxID_i;
   logic [63:0] dsp_AxADDR_i;
   logic [3:0]  dsp_AxBURST_i;
   logic [5:0]  dsp_AxLEN_i, dsp_AxSIZE_i;
   logic [1:0]  dsp_AxREADY_o;
   logic [5:0]  s_AxID_o;
   logic [31:0] s_AxADDR_o;
   logic [1:0]  s_AxBURST_o;
   logic [2:0]  s_AxLEN_o, s_AxSIZE_o;
   logic        s_AxVALID_o, xDATA_mst_id_o, xDATA_disable_o;
   logic [3:0]  outst_ctn_o;

   assign dsp_AxID_i    = {rqId[1], rqId[0]};
   assign dsp_AxADDR_i  = {rqAddr[1], rqAddr[0]};
   assign dsp_AxBURST_i = {rqBurst[1], rqBurst[0]};
   assign dsp_AxLEN_i   = {rqLen[1], rqLen[0]};
   assign dsp_AxSIZE_i  = {rqSize[1], rqSize[0]};

   sa_xaddr_arbiter dut (
      .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
      .dsp_AxID_i(dsp_AxID_i), .dsp_AxADDR_i(dsp_AxADDR_i), .dsp_AxBURST_i(dsp_AxBURST_i),
      .dsp_AxLEN_i(dsp_AxLEN_i), .dsp_AxSIZE_i(dsp_AxSIZE_i), .dsp_AxVALID_i(have),
      .dsp_AxREADY_o(dsp_AxREADY_o),
      .s_AxID_o(s_AxID_o), .s_AxADDR_o(s_AxADDR_o), .s_AxBURST_o(s_AxBURST_o),
      .s_AxLEN_o(s_AxLEN_o), .s_AxSIZE_o(s_AxSIZE_o), .s_AxVALID_o(s_AxVALID_o),
      .s_AxREADY_i(sReady), .s_xVALID_i(xValid), .s_xREADY_i(xReady),
      .xDATA_mst_id_o(xDATA_mst_id_o), .xDATA_disable_o(xDATA_disable_o), .outst_ctn_o(outst_ctn_o)
   );

   int total = 0;
   int bad = 0;

   // Reference model: registered output slot, order queue of {master, len}, beats seen on head burst
   int          mRr, mBeat, lastG;
   bit          mOv;
   logic [5:0]  mId;
   logic [31:0] mAddr;
   logic [1:0]  mBurst;
   logic [2:0]  mLen, mSize;
   int          qM[$], qL[$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mRr = 0; mBeat = 0; mOv = 0;
      mId = '0; mAddr = '0; mBurst = '0; mLen = '0; mSize = '0;
      qM.delete(); qL.delete();
   endtask

   task automatic setReq(int m, logic [4:0] id, logic [31:0] addr, logic [2:0] len);
      have[m] = 1'b1; rqId[m] = id; rqAddr[m] = addr; rqLen[m] = len;
      rqBurst[m] = 2'd1; rqSize[m] = 3'd2;
   endtask

   task automatic refill(int prob, int len);
      for (int m = 0; m < 2; m++) begin
         if (!have[m] && $urandom_range(0, 99) < prob) begin
            setReq(m, 5'($urandom_range(0, 31)), $urandom, 3'((len < 0) ? $urandom_range(0, 7) : len));
            rqBurst[m] = 2'($urandom_range(0, 3));
            rqSize[m] = 3'($urandom_range(0, 7));
         end
      end
   endtask

   task automatic cycle();
      int g;
      bit grant, hs, last;
      @(negedge ACLK_i);
      g = -1;
      for (int i = 0; i < 2; i++) if (g < 0 && have[(mRr + i) % 2]) g = (mRr + i) % 2;
      grant = (!mOv || sReady) && qM.size() < 8 && g >= 0;
      chk("ready", dsp_AxREADY_o, grant ? (64'd1 << g) : 64'd0);
      chk("avalid", s_AxVALID_o, mOv);
      if (mOv) begin
         chk("id", s_AxID_o, mId);
         chk("addr", s_AxADDR_o, mAddr);
         chk("burst", s_AxBURST_o, mBurst);
         chk("len", s_AxLEN_o, mLen);
         chk("size", s_AxSIZE_o, mSize);
      end
      chk("outst", outst_ctn_o, qM.size());
      chk("disable", xDATA_disable_o, qM.size() == 0);
      if (qM.size() > 0) chk("mstid", xDATA_mst_id_o, qM[0]);
      hs = xValid && xReady && qM.size() > 0;
      last = hs && mBeat == qL[0];
      lastG = grant ? g : -1;
      @(posedge ACLK_i);
      #1;
      if (last) begin
         void'(qM.pop_front()); void'(qL.pop_front()); mBeat = 0;
      end else if (hs) mBeat++;
      if (grant) begin
         mOv = 1; mId = {g[0], rqId[g]}; mAddr = rqAddr[g]; mBurst = rqBurst[g];
         mLen = rqLen[g]; mSize = rqSize[g];
         qM.push_back(g); qL.push_back(int'(rqLen[g]));
         mRr = (g + 1) % 2;
         have[g] = 1'b0;
      end else if (sReady) mOv = 0;
   endtask

   task automatic drain();
      int n = 0;
      xValid = 1; xReady = 1; sReady = 1;
      while ((have != 0 || qM.size() > 0 || mOv) && n < 300) begin cycle(); n++; end
      chk("drain_done", (have != 0 || qM.size() > 0 || mOv), 0);
   endtask

   task automatic resetChecks(string tag);
      chk({tag, "_avalid"}, s_AxVALID_o, 0);
      chk({tag, "_ready"}, dsp_AxREADY_o, 0);
      chk({tag, "_outst"}, outst_ctn_o, 0);
      chk({tag, "_disable"}, xDATA_disable_o, 1);
      chk({tag, "_mstid"}, xDATA_mst_id_o, 0);
      chk({tag, "_id"}, s_AxID_o, 0);
      chk({tag, "_addr"}, s_AxADDR_o, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int rrExp[4] = '{0, 1, 0, 1};
      int grants[$];
      have = 0; sReady = 0; xValid = 0; xReady = 0;
      for (int m = 0; m < 2; m++) begin
         rqId[m] = '0; rqAddr[m] = '0; rqBurst[m] = '0; rqLen[m] = '0; rqSize[m] = '0;
      end
      modelReset();
      #1;
      resetChecks("rst");
      @(negedge ACLK_i) ARESET_i = 0;
      @(posedge ACLK_i) #1;

      sReady = 1;
      setReq(1, 5'd5, 32'h4000_0010, 3'd3);
      cycle();
      chk("single_valid", s_AxVALID_o, 1);
      chk("single_id", s_AxID_o, 6'h25);
      chk("single_addr", s_AxADDR_o, 32'h4000_0010);
      chk("single_mst", xDATA_mst_id_o, 1);
      chk("single_outst", outst_ctn_o, 1);
      xValid = 1; xReady = 1;
      repeat (3) cycle();
      chk("single_3beats", xDATA_disable_o, 0);
      cycle();
      chk("single_4beats", xDATA_disable_o, 1);

      grants.delete();
      repeat (4) begin
         refill(100, -1);
         cycle();
         if (lastG >= 0) grants.push_back(lastG);
      end
      chk("rr_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_order", grants[i], rrExp[i]);

      refill(100, -1);
      cycle();
      sReady = 0; n = 0;
      repeat (5) begin
         refill(100, -1);
         cycle();
         if (lastG >= 0) n++;
      end
      chk("bp_no_grant", n, 0);
      drain();

      xValid = 0; sReady = 1; n = 0;
      repeat (12) begin
         refill(100, -1);
         cycle();
         if (lastG >= 0) n++;
      end
      chk("full_grants", n, 8);
      chk("full_outst", outst_ctn_o, 8);
      xValid = 1; xReady = 1; n = 0;
      lastG = -1;
      while (lastG < 0 && n < 20) begin cycle(); n++; end
      chk("ninth_grant", lastG >= 0, 1);
      drain();

      repeat (6) begin
         refill(100, 0);
         cycle();
      end
      chk("len0_outst", outst_ctn_o, 1);
      drain();

      repeat (3) cycle();
      xValid = 0;
      setReq(0, 5'd2, 32'h0000_0200, 3'd1);
      cycle();
      xValid = 1;
      cycle();
      chk("empty_hs_mid", xDATA_disable_o, 0);
      cycle();
      chk("empty_hs_done", xDATA_disable_o, 1);

      xValid = 0; sReady = 1;
      repeat (3) begin
         refill(100, 2);
         cycle();
      end
      chk("pre_rst_outst", outst_ctn_o, 3);
      refill(100, 2);
      ARESET_i = 1;
      #1;
      resetChecks("mid_rst");
      have = 0;
      modelReset();
      #2 ARESET_i = 0;
      setReq(1, 5'd3, 32'h0000_0300, 3'd2);
      setReq(0, 5'd9, 32'h0000_0100, 3'd0);
      cycle();
      chk("post_rst_id", s_AxID_o, 6'h09);
      chk("post_rst_mst", xDATA_mst_id_o, 0);
      drain();

      repeat (3000) begin
         sReady = $urandom_range(0, 99) < 70;
         xValid = $urandom_range(0, 99) < 60;
         xReady = $urandom_range(0, 99) < 60;
         refill(50, -1);
         cycle();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
